// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and carry-in; the slave returns registered sum, carry-out and overflow.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             y;
  logic             out_valid;
  logic             ovf;

  modport master (
    output in_valid, a, b, c,
    input  s, y, out_valid, ovf
  );

  modport slave (
    input  in_valid, a, b, c,
    output s, y, out_valid, ovf
  );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder {y, s} = a + b + c, one result per clock, 1-cycle latency.
// No back-pressure: outputs hold on idle cycles and clear asynchronously on rst.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  full_adder_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             y_d, y_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  // Ripple chain of full-adder cells; carry[0] is the external carry-in.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = bus.c;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & carry[i]) | (bus.b[i] & carry[i]);
    end
  end

  always_comb begin
    s_d         = s_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d         = sum;
      y_d         = carry[WIDTH];
      ovf_d       = carry[WIDTH] ^ carry[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      y_q         <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8 side by side.
// Expected results come from integer arithmetic on the operands, queued at each accepting edge.
module tb_full_adder;

  typedef struct {
    logic [7:0] s;
    logic       y;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  exp_t q1[$];
  exp_t q8[$];
  exp_t held1;
  exp_t held8;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unsigned sum split at bit w; overflow when the two's-complement sum leaves [-2^(w-1), 2^(w-1)-1].
  function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic c);
    exp_t   m;
    longint ua, ub, uc, total, pw, lim, sa, sb, ssum;
    ua    = longint'(a);
    ub    = longint'(b);
    uc    = longint'(c);
    total = ua + ub + uc;
    pw    = longint'(1) << w;
    lim   = pw / 2;
    m.s   = 8'(total % pw);
    m.y   = 1'(total / pw);
    sa    = (ua >= lim) ? ua - pw : ua;
    sb    = (ub >= lim) ? ub - pw : ub;
    ssum  = sa + sb + uc;
    m.ovf = (ssum >= lim) || (ssum < -lim);
    return m;
  endfunction

  task automatic check_val(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic check_res(string name, exp_t got, exp_t exp);
    check_val({name, " s"}, 64'(got.s), 64'(exp.s));
    check_val({name, " y"}, 64'(got.y), 64'(exp.y));
    check_val({name, " ovf"}, 64'(got.ovf), 64'(exp.ovf));
  endtask

  task automatic check_zero(string name);
    check_val({name, " w1 s"}, 64'(bus1.s), 64'd0);
    check_val({name, " w1 y"}, 64'(bus1.y), 64'd0);
    check_val({name, " w1 ovf"}, 64'(bus1.ovf), 64'd0);
    check_val({name, " w1 out_valid"}, 64'(bus1.out_valid), 64'd0);
    check_val({name, " w8 s"}, 64'(bus8.s), 64'd0);
    check_val({name, " w8 y"}, 64'(bus8.y), 64'd0);
    check_val({name, " w8 ovf"}, 64'(bus8.ovf), 64'd0);
    check_val({name, " w8 out_valid"}, 64'(bus8.out_valid), 64'd0);
  endtask

  task automatic flush();
    q1.delete();
    q8.delete();
    held1 = '{s: 8'd0, y: 1'b0, ovf: 1'b0};
    held8 = '{s: 8'd0, y: 1'b0, ovf: 1'b0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(logic v, logic a, logic b, logic c);
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.c        = c;
  endtask

  task automatic drive8(logic v, logic [7:0] a, logic [7:0] b, logic c);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.c        = c;
  endtask

  task automatic drive_random(bit force_valid);
    drive1(force_valid ? 1'b1 : 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive8(force_valid ? 1'b1 : 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // Scoreboard push: every edge that accepts operands yields one expected result.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus1.in_valid === 1'b1) q1.push_back(model(1, {7'd0, bus1.a}, {7'd0, bus1.b}, bus1.c));
      if (bus8.in_valid === 1'b1) q8.push_back(model(8, bus8.a, bus8.b, bus8.c));
    end
  end

  // Monitor: a pending result must be presented with out_valid; otherwise the last result holds.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst) begin
      got = '{s: {7'd0, bus1.s}, y: bus1.y, ovf: bus1.ovf};
      check_val("w1 out_valid", 64'(bus1.out_valid), 64'(q1.size() != 0));
      if (q1.size() != 0) begin
        e     = q1.pop_front();
        check_res("w1 result", got, e);
        held1 = e;
      end else begin
        check_res("w1 hold", got, held1);
      end

      got = '{s: bus8.s, y: bus8.y, ovf: bus8.ovf};
      check_val("w8 out_valid", 64'(bus8.out_valid), 64'(q8.size() != 0));
      if (q8.size() != 0) begin
        e     = q8.pop_front();
        check_res("w8 result", got, e);
        held8 = e;
      end else begin
        check_res("w8 hold", got, held8);
      end
    end
  end

  logic [7:0] bnd_a [3] = '{8'hFF, 8'h7F, 8'hFF};
  logic [7:0] bnd_b [3] = '{8'h00, 8'h01, 8'hFF};
  logic       bnd_c [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    flush();
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'd1, 8'd1, 1'b1);

    // Reset must clear outputs before any clock edge and keep them clear.
    #1 rst = 1'b1;
    #1 check_zero("reset immediate");
    repeat (2) begin
      @(negedge clk);
      check_zero("reset held");
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    #2 rst = 1'b0;
    tick();

    // WIDTH=1 truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, i[2], i[1], i[0]);
      tick();
    end
    // Idle with changed operands: last result (1,1) must hold.
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // WIDTH=8 carry and overflow boundaries.
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, bnd_a[i], bnd_b[i], bnd_c[i]);
      tick();
    end
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    tick();

    // Back-to-back stream.
    repeat (16) begin
      drive_random(1'b1);
      tick();
    end

    // Asynchronous reset pulse between edges in the middle of a stream.
    repeat (4) begin
      drive_random(1'b1);
      tick();
    end
    drive_random(1'b1);
    #1 rst = 1'b1;
    flush();
    #1 check_zero("mid-stream reset");
    rst = 1'b0;
    tick();
    repeat (6) begin
      drive_random(1'b1);
      tick();
    end

    // Random valid/idle mix.
    repeat (40) begin
      drive_random(1'b0);
      tick();
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
